// File: rtl/cpu_pkg.sv
// Shared arbiter types: FSM state encoding and the grant-select code produced
// by the request decoder.
package cpu_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_IFETCH,
      ARB_DATA
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_IF,
      GNT_DATA
   } gnt_sel_t;

   // Picks the port to issue from IDLE; prio_data breaks a tie.
   function automatic gnt_sel_t pick_grant(input logic pend_if,
                                           input logic pend_data,
                                           input logic prio_data);
      if (pend_if && pend_data) return prio_data ? GNT_DATA : GNT_IF;
      if (pend_data)            return GNT_DATA;
      if (pend_if)              return GNT_IF;
      return GNT_NONE;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events; holds at all-ones instead of
// wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i)                         count_d = '0;
      else if (inc_i && count_q != '1)   count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises instruction fetch and load/store onto one single-port memory and
// stalls the whole pipeline until every pending access of this cycle is served.
module unified_mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 16,
   parameter int PRIO_DATA = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_read_i,
   input  logic              d_write_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam logic prio_data_c = (PRIO_DATA != 0);

   arb_state_t        state_q, state_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic     d_req, pend_i, pend_d;
   gnt_sel_t gnt;

   // Done flags mask a request that is still held while the pipeline is frozen.
   assign d_req   = d_read_i | d_write_i;
   assign pend_i  = if_req_i & ~if_done_q;
   assign pend_d  = d_req & ~d_done_q;
   assign stall_o = pend_i | pend_d;
   assign gnt     = pick_grant(pend_i, pend_d, prio_data_c);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      if_done_d   = if_done_q;
      d_done_d    = d_done_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;

      if (!stall_o) begin
         if_done_d = 1'b0;
         d_done_d  = 1'b0;
      end

      case (state_q)
         ARB_IDLE: begin
            case (gnt)
               GNT_IF: begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr_i;
                  mem_wdata_d = '0;
                  state_d     = ARB_IFETCH;
               end
               GNT_DATA: begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = d_write_i;
                  mem_addr_d  = d_addr_i;
                  mem_wdata_d = d_write_i ? d_wdata_i : '0;
                  state_d     = ARB_DATA;
               end
               default: ;
            endcase
         end
         ARB_IFETCH: begin
            if (mem_ack_i) begin
               mem_req_d = 1'b0;
               state_d   = ARB_IDLE;
               // A fetch dropped while in flight completes on the bus but is discarded.
               if (if_req_i) begin
                  if_rdata_d = mem_rdata_i;
                  if_done_d  = 1'b1;
               end
            end
         end
         ARB_DATA: begin
            if (mem_ack_i) begin
               mem_req_d = 1'b0;
               state_d   = ARB_IDLE;
               if (d_req) begin
                  if (!mem_we_q) d_rdata_d = mem_rdata_i;
                  d_done_d = 1'b1;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking updates so every register samples pre-edge values together.
      if (!rst_i) begin
         state_q     <= ARB_IDLE;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         assert (!(d_read_i && d_write_i))
            else $error("d_read_i and d_write_i both set; store takes precedence");
      end
   end
`endif

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (stall_o),
      .clr_i   (1'b0),
      .count_o (stall_cnt_o)
   );

   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Two arbiters share the pipeline-side stimulus: dut0 (data priority, 16-bit
// counter) and dut1 (fetch priority, 4-bit counter), each with its own memory.
module tb_unified_mem_arbiter;

   typedef struct {
      int          cyc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } issue_t;

   typedef struct {
      logic        is_fetch;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   int          waits = 0;
   logic        force_ack = 1'b0;

   logic        stall[2];
   logic        mem_req[2];
   logic        mem_we[2];
   logic        mem_ack[2];
   logic [31:0] mem_addr[2];
   logic [31:0] mem_wdata[2];
   logic [31:0] mem_rdata[2];
   logic [31:0] if_rdata[2];
   logic [31:0] d_rdata[2];
   logic [15:0] stall_cnt[2];

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] ref_mem[2][256];
   logic [31:0] exp_if[2];
   logic [31:0] exp_d[2];
   int          tot[2];
   issue_t      log_a[2][4];
   int          log_n[2];

   function automatic logic [31:0] init_word(int i);
      if (i == 4) return 32'h8C22_0004;
      return 32'h1357_0000 | (i * 32'h0000_0111);
   endfunction

   function automatic int cnt_max(int g);
      return (g == 0) ? 65535 : 15;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int CW = (g == 0) ? 16 : 4;
      logic [CW-1:0] cnt;
      logic [31:0]   mem_a[256];
      int            wcnt;

      unified_mem_arbiter #(
         .ADDR_W(32), .DATA_W(32), .CNT_W(CW), .PRIO_DATA((g == 0) ? 1 : 0)
      ) dut (
         .clk_i       (clk),
         .rst_i       (rst_i),
         .if_req_i    (if_req),
         .if_addr_i   (if_addr),
         .if_rdata_o  (if_rdata[g]),
         .d_read_i    (d_read),
         .d_write_i   (d_write),
         .d_addr_i    (d_addr),
         .d_wdata_i   (d_wdata),
         .d_rdata_o   (d_rdata[g]),
         .stall_o     (stall[g]),
         .mem_req_o   (mem_req[g]),
         .mem_we_o    (mem_we[g]),
         .mem_addr_o  (mem_addr[g]),
         .mem_wdata_o (mem_wdata[g]),
         .mem_rdata_i (mem_rdata[g]),
         .mem_ack_i   (mem_ack[g]),
         .stall_cnt_o (cnt)
      );

      assign stall_cnt[g] = 16'(cnt);
      assign mem_ack[g]   = (mem_req[g] && (wcnt == waits)) || force_ack;
      assign mem_rdata[g] = mem_a[mem_addr[g][9:2]];

      initial begin
         wcnt = 0;
         for (int i = 0; i < 256; i++) mem_a[i] = init_word(i);
      end

      always @(posedge clk) begin
         if (mem_req[g] && !mem_ack[g]) wcnt <= wcnt + 1;
         else                           wcnt <= 0;
         if (mem_req[g] && mem_ack[g] && mem_we[g]) mem_a[mem_addr[g][9:2]] <= mem_wdata[g];
      end
   end

   task automatic model_reset();
      for (int g = 0; g < 2; g++) begin
         exp_if[g] = '0;
         exp_d[g]  = '0;
         tot[g]    = 0;
      end
   endtask

   // One pipeline step: requests raised at cycle 0 and held until stall_o drops.
   task automatic do_txn(input string name, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dwd, input int w);
      int   first0[2];
      logic last_req[2];
      acc_t ord[2];
      acc_t af, ad;
      int   n_acc, exp_stall, idx, exp_cnt;

      waits = w;
      @(posedge clk); #1;
      if_req = ir; if_addr = ia; d_read = dr; d_write = dw; d_addr = da; d_wdata = dwd;
      for (int g = 0; g < 2; g++) begin
         log_n[g] = 0; first0[g] = -1; last_req[g] = 1'b0;
      end
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (first0[g] < 0) begin
               if (mem_req[g] && !last_req[g]) begin
                  if (log_n[g] < 4) log_a[g][log_n[g]] = '{c, mem_we[g], mem_addr[g], mem_wdata[g]};
                  log_n[g]++;
               end else if (mem_req[g] && log_n[g] > 0 && log_n[g] <= 4) begin
                  n_checks++;
                  if ({mem_we[g], mem_addr[g], mem_wdata[g]} !==
                      {log_a[g][log_n[g]-1].we, log_a[g][log_n[g]-1].addr, log_a[g][log_n[g]-1].wdata}) begin
                     n_fail++;
                     $display("FAIL %s dut%0d mem bus moved while waiting: got we=%0b addr=%h wdata=%h expected we=%0b addr=%h wdata=%h",
                              name, g, mem_we[g], mem_addr[g], mem_wdata[g], log_a[g][log_n[g]-1].we,
                              log_a[g][log_n[g]-1].addr, log_a[g][log_n[g]-1].wdata);
                  end
               end
               last_req[g] = mem_req[g];
               if (!stall[g]) first0[g] = c;
            end
         end
         if (first0[0] >= 0 && first0[1] >= 0) break;
         @(posedge clk); #1;
      end

      for (int g = 0; g < 2; g++) begin
         af = '{1'b1, 1'b0, ia, 32'h0};
         ad = '{1'b0, dw, da, dw ? dwd : 32'h0};
         n_acc = 0;
         if (ir && (dr || dw)) begin
            if (g == 0) ord = '{ad, af};
            else        ord = '{af, ad};
            n_acc = 2;
         end else if (ir) begin
            ord[0] = af; n_acc = 1;
         end else if (dr || dw) begin
            ord[0] = ad; n_acc = 1;
         end
         exp_stall = n_acc * (w + 2);

         n_checks++;
         if (first0[g] !== exp_stall) begin
            n_fail++;
            $display("FAIL %s dut%0d stall cycles: got %0d expected %0d (-1 = never advanced)",
                     name, g, first0[g], exp_stall);
         end
         n_checks++;
         if (log_n[g] !== n_acc) begin
            n_fail++;
            $display("FAIL %s dut%0d issued accesses: got %0d expected %0d", name, g, log_n[g], n_acc);
         end
         for (int k = 0; k < n_acc && k < log_n[g] && k < 4; k++) begin
            n_checks++;
            if (log_a[g][k].cyc !== 1 + k * (w + 2) || log_a[g][k].we !== ord[k].we ||
                log_a[g][k].addr !== ord[k].addr || log_a[g][k].wdata !== ord[k].wdata) begin
               n_fail++;
               $display("FAIL %s dut%0d issue %0d: got cyc=%0d we=%0b addr=%h wdata=%h expected cyc=%0d we=%0b addr=%h wdata=%h",
                        name, g, k, log_a[g][k].cyc, log_a[g][k].we, log_a[g][k].addr, log_a[g][k].wdata,
                        1 + k * (w + 2), ord[k].we, ord[k].addr, ord[k].wdata);
            end
         end

         for (int k = 0; k < n_acc; k++) begin
            idx = int'(ord[k].addr[9:2]);
            if (ord[k].is_fetch)  exp_if[g] = ref_mem[g][idx];
            else if (ord[k].we)   ref_mem[g][idx] = ord[k].wdata;
            else                  exp_d[g] = ref_mem[g][idx];
         end
         tot[g] += exp_stall;
         exp_cnt = (tot[g] > cnt_max(g)) ? cnt_max(g) : tot[g];

         n_checks++;
         if (if_rdata[g] !== exp_if[g]) begin
            n_fail++;
            $display("FAIL %s dut%0d if_rdata: got %h expected %h", name, g, if_rdata[g], exp_if[g]);
         end
         n_checks++;
         if (d_rdata[g] !== exp_d[g]) begin
            n_fail++;
            $display("FAIL %s dut%0d d_rdata: got %h expected %h", name, g, d_rdata[g], exp_d[g]);
         end
         n_checks++;
         if (stall_cnt[g] !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s dut%0d stall_cnt: got %0d expected %0d", name, g, stall_cnt[g], exp_cnt);
         end
      end

      @(posedge clk); #1;
      if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if ({mem_req[g], mem_we[g], mem_addr[g], mem_wdata[g], if_rdata[g], d_rdata[g], stall_cnt[g], stall[g]} !== '0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: got req=%0b addr=%h if_rdata=%h d_rdata=%h cnt=%0d expected all zero",
                     g, mem_req[g], mem_addr[g], if_rdata[g], d_rdata[g], stall_cnt[g]);
         end
      end
      @(posedge clk); #1;
      rst_i = 1'b1;
      model_reset();

      // Abort an in-flight fetch with reset, then deliver a late ack.
      waits = 7;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h40;
      @(posedge clk); #1;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if (mem_req[g] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midaccess_issue dut%0d mem_req: got %0b expected 1", g, mem_req[g]);
         end
      end
      #1;
      rst_i = 1'b0; if_req = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b1; force_ack = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if ({mem_req[g], stall[g], stall_cnt[g]} !== '0) begin
            n_fail++;
            $display("FAIL reset_abort dut%0d: got req=%0b stall=%0b cnt=%0d expected 0 0 0",
                     g, mem_req[g], stall[g], stall_cnt[g]);
         end
      end
      @(posedge clk); #1;
      force_ack = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if ({mem_req[g], if_rdata[g], d_rdata[g]} !== '0) begin
            n_fail++;
            $display("FAIL reset_late_ack dut%0d: got req=%0b if_rdata=%h d_rdata=%h expected all zero",
                     g, mem_req[g], if_rdata[g], d_rdata[g]);
         end
      end
   endtask

   task automatic test_single_fetch();
      do_txn("single_fetch", 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_contention();
      do_txn("contention", 1'b1, 32'h0000_0014, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 0);
   endtask

   task automatic test_store_wait();
      do_txn("store_wait3", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 3);
      do_txn("load_after_store", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1);
   endtask

   task automatic test_same_addr_order();
      do_txn("store_vs_fetch_order", 1'b1, 32'h0000_0030, 1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_0123, 1);
   endtask

   task automatic test_drop();
      int c;
      waits = 3;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h0000_0044;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if (stall[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_unstall dut%0d stall: got %0b expected 0", g, stall[g]);
         end
         tot[g] += 2;
      end
      c = 0;
      while ((mem_req[0] || mem_req[1]) && c < 20) begin
         @(negedge clk); c++;
      end
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         n_checks++;
         if ({mem_req[g], if_rdata[g]} !== {1'b0, exp_if[g]}) begin
            n_fail++;
            $display("FAIL drop_discard dut%0d: got req=%0b if_rdata=%h expected req=0 if_rdata=%h",
                     g, mem_req[g], if_rdata[g], exp_if[g]);
         end
      end
   endtask

   task automatic test_saturation();
      do_txn("saturation", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0024, 32'h0BAD_F00D, 18);
      n_checks++;
      if (stall_cnt[1] !== 16'h000F) begin
         n_fail++;
         $display("FAIL saturation_cap dut1 stall_cnt: got %h expected 000f", stall_cnt[1]);
      end
   endtask

   task automatic test_random();
      logic        ir;
      int          op;
      logic [31:0] ia, da;
      for (int t = 0; t < 30; t++) begin
         ir = 1'($urandom_range(0, 1));
         op = int'($urandom_range(0, 2));
         ia = {22'h0, 8'($urandom_range(0, 7)), 2'b00};
         da = {22'h0, 8'($urandom_range(0, 7)), 2'b00};
         do_txn($sformatf("random_%0d", t), ir, ia, op == 1, op == 2, da, $urandom, int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      for (int g = 0; g < 2; g++)
         for (int i = 0; i < 256; i++) ref_mem[g][i] = init_word(i);
      model_reset();
      test_reset();
      test_single_fetch();
      test_contention();
      test_store_wait();
      test_same_addr_order();
      test_drop();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
